// File: rtl/ibuffer_warp_gen.sv
// ibuffer_warp_gen
// Per-warp instruction buffer sitting between the dual decode stage and the
// issue unit / operand collector. Holds DEPTH decoded instructions with an
// opaque payload, issues the head in order under scoreboard gating, tracks one
// outstanding memory instruction for per-thread replay, and retires EXIT.
//
// Three pointers walk a circular array (one extra wrap bit each):
//   wp  - next free slot for decode writes
//   rp  - oldest not-yet-issued entry (head)
//   irp - oldest still-resident entry; differs from rp only while a memory
//         instruction is outstanding awaiting completion feedback
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_pending, req_if       fetch throttling towards IF
//   wr_*_0 / wr_*_1          two decoded instructions per cycle (slot 0 older)
//   active_mask, drop, flush SIMT mask for writes, write suppression, discard
//   oc_full, scb_*           issue gating and scoreboard ID for the head
//   iss_*                    issue request/grant towards the IU
//   scb_alloc                head granted; scoreboard allocates scb_id
//   fb_*                     memory completion feedback for the irp entry
//   replay_done*             outstanding memory instruction fully served
//   exit_req, exit_grt       EXIT retirement handshake
//   occupancy, overflow_err  wp-irp, sticky write-overflow flag
module ibuffer_warp_gen #(
  parameter int NUM_THREADS = 8,
  parameter int DEPTH       = 4,
  parameter int PAYLOAD_W   = 64,
  parameter int SCB_ID_W    = 2,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int PTR_W      = IDX_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             if_pending,
  output logic                   req_if,
  input  logic                   wr_valid_0,
  input  logic                   wr_valid_1,
  input  logic [PAYLOAD_W-1:0]   wr_payload_0,
  input  logic [PAYLOAD_W-1:0]   wr_payload_1,
  input  logic                   wr_mem_0,
  input  logic                   wr_mem_1,
  input  logic                   wr_exit_0,
  input  logic                   wr_exit_1,
  input  logic [NUM_THREADS-1:0] active_mask,
  input  logic                   drop,
  input  logic                   flush,
  input  logic                   oc_full,
  input  logic                   scb_block,
  input  logic                   scb_empty,
  input  logic [SCB_ID_W-1:0]    scb_id,
  output logic                   iss_req,
  input  logic                   iss_grt,
  output logic                   iss_replay,
  output logic [PAYLOAD_W-1:0]   iss_payload,
  output logic [NUM_THREADS-1:0] iss_mask,
  output logic [SCB_ID_W-1:0]    iss_scb_id,
  output logic                   scb_alloc,
  input  logic                   fb_pos_valid,
  input  logic [NUM_THREADS-1:0] fb_pos_mask,
  input  logic                   fb_zero_valid,
  output logic                   replay_done,
  output logic [SCB_ID_W-1:0]    replay_done_scb_id,
  output logic                   exit_req,
  input  logic                   exit_grt,
  output logic [PTR_W-1:0]       occupancy,
  output logic                   overflow_err
);

  // Control state
  logic [PTR_W-1:0] wp, rp, irp;
  logic [DEPTH-1:0] ent_valid, ent_replay, ent_mem, ent_exit;
  logic             ovf_q;

  // Data state (no reset needed: only read behind a valid bit)
  logic [NUM_THREADS-1:0] ent_mask    [DEPTH];
  logic [SCB_ID_W-1:0]    ent_scb     [DEPTH];
  logic [PAYLOAD_W-1:0]   ent_payload [DEPTH];

  logic [IDX_W-1:0] wp_idx, rp_idx, irp_idx, w1_idx, rpn_idx;
  logic [PTR_W-1:0] occ, rp_next, irp_next, wp_next, flush_cnt;
  logic [1:0]       n_wr;
  logic [PTR_W:0]   space;
  logic [PTR_W+1:0] demand;
  logic             do_write, wr_ovf;
  logic             irp_live, mask_next_nz, replay_cond, head_base, sel_replay;
  logic             head_grant, replay_grant, exit_fire, fb_done;
  logic [NUM_THREADS-1:0] mask_next;
  logic [DEPTH-1:0] flush_kill, valid_clr, valid_nxt, replay_nxt, mem_nxt, exit_nxt;

  assign wp_idx  = wp[IDX_W-1:0];
  assign rp_idx  = rp[IDX_W-1:0];
  assign irp_idx = irp[IDX_W-1:0];
  // Slot 1 lands right after slot 0, or at wp itself when slot 0 is empty.
  assign w1_idx  = wp_idx + IDX_W'(wr_valid_0);

  assign occ       = wp - irp;
  assign occupancy = occ;

  // Writes are all-or-nothing: a pair that does not fit is dropped entirely.
  assign n_wr     = (drop | flush) ? 2'd0 : ({1'b0, wr_valid_0} + {1'b0, wr_valid_1});
  assign space    = (PTR_W+1)'(DEPTH) - {1'b0, occ};
  assign wr_ovf   = {{(PTR_W-1){1'b0}}, n_wr} > space;
  assign do_write = (n_wr != 2'd0) && !wr_ovf;

  assign demand = {2'b00, occ} + (PTR_W+2)'(if_pending) + (PTR_W+2)'(n_wr);
  assign req_if = demand < (PTR_W+2)'(DEPTH);

  // Feedback always targets the outstanding memory entry at irp.
  assign irp_live     = (irp != rp) && ent_valid[irp_idx];
  assign mask_next    = fb_pos_valid ? (ent_mask[irp_idx] & ~fb_pos_mask) : ent_mask[irp_idx];
  assign mask_next_nz = |mask_next;
  assign fb_done      = irp_live & ~mask_next_nz;
  assign replay_cond  = ent_replay[irp_idx] | fb_zero_valid | (fb_pos_valid & mask_next_nz);

  assign head_base = ent_valid[rp_idx] & ~ent_exit[rp_idx] & ~scb_block & ~oc_full;

  // Replay has priority; with a memory op outstanding only non-mem heads may
  // issue, which keeps at most one memory instruction in flight.
  always_comb begin
    sel_replay = 1'b0;
    iss_req    = 1'b0;
    if (!irp_live) begin
      iss_req = head_base;
    end else if (replay_cond) begin
      sel_replay = 1'b1;
      iss_req    = ~oc_full;
    end else begin
      iss_req = head_base & ~ent_mem[rp_idx];
    end
  end

  assign iss_replay   = sel_replay;
  assign iss_payload  = sel_replay ? ent_payload[irp_idx] : ent_payload[rp_idx];
  // A replay carries only the threads still unserved, including this cycle's feedback.
  assign iss_mask     = sel_replay ? mask_next : ent_mask[rp_idx];
  assign iss_scb_id   = ent_scb[irp_idx];
  assign head_grant   = iss_req & iss_grt & ~sel_replay;
  assign replay_grant = iss_req & iss_grt & sel_replay;
  assign scb_alloc    = head_grant;

  assign replay_done        = fb_done;
  assign replay_done_scb_id = ent_scb[irp_idx];

  assign exit_req  = ent_valid[rp_idx] & ent_exit[rp_idx] & scb_empty & (irp == rp);
  assign exit_fire = exit_req & exit_grt;

  assign rp_next   = rp + PTR_W'(head_grant | exit_fire);
  assign rpn_idx   = rp_next[IDX_W-1:0];
  assign flush_cnt = wp - rp_next;

  // Entries in [rp_next, wp) are the not-yet-issued ones a flush discards.
  always_comb begin
    flush_kill = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PTR_W'(k) < flush_cnt) begin
        flush_kill[rpn_idx + IDX_W'(k)] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_clr  = ent_valid;
    replay_nxt = ent_replay;
    if (fb_done) begin
      valid_clr[irp_idx] = 1'b0;
    end else if (irp_live & (fb_pos_valid | fb_zero_valid)) begin
      replay_nxt[irp_idx] = 1'b1;
    end
    // A replay granted this cycle already carries this cycle's feedback mask.
    if (replay_grant) replay_nxt[irp_idx] = 1'b0;
    if (head_grant) begin
      replay_nxt[rp_idx] = 1'b0;
      // Memory entries stay resident until all threads are served.
      if (!ent_mem[rp_idx]) valid_clr[rp_idx] = 1'b0;
    end
    if (exit_fire) valid_clr[rp_idx] = 1'b0;

    valid_nxt = valid_clr;
    mem_nxt   = ent_mem;
    exit_nxt  = ent_exit;
    if (flush) begin
      valid_nxt = valid_clr & ~flush_kill;
    end else if (do_write) begin
      if (wr_valid_0) begin
        valid_nxt[wp_idx]  = 1'b1;
        replay_nxt[wp_idx] = 1'b0;
        mem_nxt[wp_idx]    = wr_mem_0;
        exit_nxt[wp_idx]   = wr_exit_0;
      end
      if (wr_valid_1) begin
        valid_nxt[w1_idx]  = 1'b1;
        replay_nxt[w1_idx] = 1'b0;
        mem_nxt[w1_idx]    = wr_mem_1;
        exit_nxt[w1_idx]   = wr_exit_1;
      end
    end
  end

  // irp catches up with the head once its entry has been released; a write
  // landing on an empty irp slot leaves irp == rp_next == rp anyway.
  assign irp_next = valid_clr[irp_idx] ? irp : rp_next;

  always_comb begin
    wp_next = wp;
    if (flush)         wp_next = rp_next;
    else if (do_write) wp_next = wp + PTR_W'(n_wr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      irp        <= '0;
      ent_valid  <= '0;
      ent_replay <= '0;
      ent_mem    <= '0;
      ent_exit   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wp         <= wp_next;
      rp         <= rp_next;
      irp        <= irp_next;
      ent_valid  <= valid_nxt;
      ent_replay <= replay_nxt;
      ent_mem    <= mem_nxt;
      ent_exit   <= exit_nxt;
      if (wr_ovf) ovf_q <= 1'b1;
    end
  end

  assign overflow_err = ovf_q;

  always_ff @(posedge clk) begin
    if (irp_live) ent_mask[irp_idx] <= mask_next;
    if (head_grant) ent_scb[rp_idx] <= scb_id;
    if (do_write) begin
      if (wr_valid_0) begin
        ent_mask[wp_idx]    <= active_mask;
        ent_payload[wp_idx] <= wr_payload_0;
      end
      if (wr_valid_1) begin
        ent_mask[w1_idx]    <= active_mask;
        ent_payload[w1_idx] <= wr_payload_1;
      end
    end
  end

endmodule

// File: tb/tb_ibuffer_warp_gen.sv
module tb_ibuffer_warp_gen;

  logic        clk, rst;
  logic [1:0]  if_pending;
  logic        req_if;
  logic        wr_valid_0, wr_valid_1;
  logic [63:0] wr_payload_0, wr_payload_1;
  logic        wr_mem_0, wr_mem_1, wr_exit_0, wr_exit_1;
  logic [7:0]  active_mask;
  logic        drop, flush, oc_full, scb_block, scb_empty;
  logic [1:0]  scb_id;
  logic        iss_req, iss_grt, iss_replay;
  logic [63:0] iss_payload;
  logic [7:0]  iss_mask;
  logic [1:0]  iss_scb_id;
  logic        scb_alloc;
  logic        fb_pos_valid;
  logic [7:0]  fb_pos_mask;
  logic        fb_zero_valid;
  logic        replay_done;
  logic [1:0]  replay_done_scb_id;
  logic        exit_req, exit_grt;
  logic [2:0]  occupancy;
  logic        overflow_err;

  ibuffer_warp_gen #(.NUM_THREADS(8), .DEPTH(4), .PAYLOAD_W(64), .SCB_ID_W(2)) dut (
    .clk(clk), .rst(rst), .if_pending(if_pending), .req_if(req_if),
    .wr_valid_0(wr_valid_0), .wr_valid_1(wr_valid_1),
    .wr_payload_0(wr_payload_0), .wr_payload_1(wr_payload_1),
    .wr_mem_0(wr_mem_0), .wr_mem_1(wr_mem_1),
    .wr_exit_0(wr_exit_0), .wr_exit_1(wr_exit_1),
    .active_mask(active_mask), .drop(drop), .flush(flush),
    .oc_full(oc_full), .scb_block(scb_block), .scb_empty(scb_empty), .scb_id(scb_id),
    .iss_req(iss_req), .iss_grt(iss_grt), .iss_replay(iss_replay),
    .iss_payload(iss_payload), .iss_mask(iss_mask), .iss_scb_id(iss_scb_id),
    .scb_alloc(scb_alloc), .fb_pos_valid(fb_pos_valid), .fb_pos_mask(fb_pos_mask),
    .fb_zero_valid(fb_zero_valid), .replay_done(replay_done),
    .replay_done_scb_id(replay_done_scb_id), .exit_req(exit_req), .exit_grt(exit_grt),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle();
    if_pending = 2'd0; wr_valid_0 = 0; wr_valid_1 = 0;
    wr_payload_0 = '0; wr_payload_1 = '0;
    wr_mem_0 = 0; wr_mem_1 = 0; wr_exit_0 = 0; wr_exit_1 = 0;
    active_mask = 8'hFF; drop = 0; flush = 0; oc_full = 0; scb_block = 0;
    scb_empty = 1; scb_id = 2'd0; iss_grt = 0; fb_pos_valid = 0; fb_pos_mask = 8'h00;
    fb_zero_valid = 0; exit_grt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v0, v1;
    logic [7:0] p0, p1;
    logic       grt, fl, dr;
    logic       ireq;
    logic [7:0] ipay;
    logic       alloc, rqif;
    logic [2:0] occ;
    logic       ovf;
  } vec_t;

  function automatic vec_t row(input logic v0, input logic v1, input logic [7:0] p0,
                               input logic [7:0] p1, input logic grt, input logic fl,
                               input logic dr, input logic ireq, input logic [7:0] ipay,
                               input logic alloc, input logic rqif, input logic [2:0] occ,
                               input logic ovf);
    vec_t r;
    r.v0 = v0; r.v1 = v1; r.p0 = p0; r.p1 = p1; r.grt = grt; r.fl = fl; r.dr = dr;
    r.ireq = ireq; r.ipay = ipay; r.alloc = alloc; r.rqif = rqif; r.occ = occ; r.ovf = ovf;
    return r;
  endfunction

  localparam int NV = 24;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    //            v0 v1 p0     p1     grt fl dr  ireq ipay  alloc rqif occ ovf
    tbl[0]  = row(1, 1, 8'h10, 8'h11, 0,  0, 0,  0, 8'h00, 0,   1,   0,  0);
    tbl[1]  = row(1, 1, 8'h20, 8'h21, 0,  0, 0,  1, 8'h10, 0,   0,   2,  0);
    tbl[2]  = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h10, 1,   0,   4,  0);
    tbl[3]  = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h11, 1,   1,   3,  0);
    tbl[4]  = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h20, 1,   1,   2,  0);
    tbl[5]  = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h21, 1,   1,   1,  0);
    tbl[6]  = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  0, 8'h00, 0,   1,   0,  0);
    tbl[7]  = row(1, 1, 8'h30, 8'h31, 0,  0, 0,  0, 8'h00, 0,   1,   0,  0);
    tbl[8]  = row(1, 0, 8'h32, 8'h00, 0,  0, 0,  1, 8'h30, 0,   1,   2,  0);
    tbl[9]  = row(1, 1, 8'h40, 8'h41, 0,  0, 0,  1, 8'h30, 0,   0,   3,  0);
    tbl[10] = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h30, 1,   1,   3,  1);
    tbl[11] = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h31, 1,   1,   2,  1);
    tbl[12] = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h32, 1,   1,   1,  1);
    tbl[13] = row(0, 0, 8'h00, 8'h00, 0,  0, 0,  0, 8'h00, 0,   1,   0,  1);
    tbl[14] = row(0, 1, 8'h00, 8'h50, 0,  0, 1,  0, 8'h00, 0,   1,   0,  1);
    tbl[15] = row(0, 1, 8'h00, 8'h51, 0,  0, 0,  0, 8'h00, 0,   1,   0,  1);
    tbl[16] = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h51, 1,   1,   1,  1);
    tbl[17] = row(0, 0, 8'h00, 8'h00, 0,  0, 0,  0, 8'h00, 0,   1,   0,  1);
    tbl[18] = row(1, 1, 8'h60, 8'h61, 0,  0, 0,  0, 8'h00, 0,   1,   0,  1);
    tbl[19] = row(1, 0, 8'h62, 8'h00, 0,  0, 0,  1, 8'h60, 0,   1,   2,  1);
    tbl[20] = row(1, 0, 8'h70, 8'h00, 1,  1, 0,  1, 8'h60, 1,   1,   3,  1);
    tbl[21] = row(1, 0, 8'h71, 8'h00, 1,  0, 0,  0, 8'h00, 0,   1,   0,  1);
    tbl[22] = row(0, 0, 8'h00, 8'h00, 1,  0, 0,  1, 8'h71, 1,   1,   1,  1);
    tbl[23] = row(0, 0, 8'h00, 8'h00, 0,  0, 0,  0, 8'h00, 0,   1,   0,  1);

    // Reset state
    idle();
    rst = 1;
    @(negedge clk);
    chk("rst iss_req", iss_req, 0);
    chk("rst exit_req", exit_req, 0);
    chk("rst scb_alloc", scb_alloc, 0);
    chk("rst replay_done", replay_done, 0);
    chk("rst occupancy", occupancy, 0);
    chk("rst req_if", req_if, 1);
    chk("rst overflow_err", overflow_err, 0);
    tick();
    rst = 0;

    // Streaming, overflow, drop, slot-1-only and flush vectors
    for (int i = 0; i < NV; i++) begin
      idle();
      wr_valid_0 = tbl[i].v0; wr_valid_1 = tbl[i].v1;
      wr_payload_0 = {56'h0, tbl[i].p0}; wr_payload_1 = {56'h0, tbl[i].p1};
      iss_grt = tbl[i].grt; flush = tbl[i].fl; drop = tbl[i].dr;
      @(negedge clk);
      chk($sformatf("r%0d iss_req", i), iss_req, tbl[i].ireq);
      if (tbl[i].ireq) chk($sformatf("r%0d iss_payload", i), iss_payload, {56'h0, tbl[i].ipay});
      chk($sformatf("r%0d scb_alloc", i), scb_alloc, tbl[i].alloc);
      chk($sformatf("r%0d req_if", i), req_if, tbl[i].rqif);
      chk($sformatf("r%0d occupancy", i), occupancy, tbl[i].occ);
      chk($sformatf("r%0d overflow_err", i), overflow_err, tbl[i].ovf);
      tick();
    end

    // LW with partial feedback, replay, then completion
    idle(); wr_valid_0 = 1; wr_payload_0 = 64'hA0; wr_mem_0 = 1;
    wr_valid_1 = 1; wr_payload_1 = 64'hA1; tick();
    idle(); iss_grt = 1; scb_id = 2'd2;
    @(negedge clk);
    chk("lw head req", iss_req, 1);
    chk("lw head payload", iss_payload, 64'hA0);
    chk("lw head alloc", scb_alloc, 1);
    tick();
    idle();
    @(negedge clk);
    chk("alu behind lw req", iss_req, 1);
    chk("alu behind lw replay", iss_replay, 0);
    chk("alu behind lw payload", iss_payload, 64'hA1);
    chk("lw outstanding occ", occupancy, 2);
    tick();
    idle(); fb_pos_valid = 1; fb_pos_mask = 8'h0F; iss_grt = 1;
    @(negedge clk);
    chk("lw partial replay req", iss_req, 1);
    chk("lw partial iss_replay", iss_replay, 1);
    chk("lw partial iss_mask", iss_mask, 8'hF0);
    chk("lw partial iss_scb_id", iss_scb_id, 2);
    chk("lw partial payload", iss_payload, 64'hA0);
    chk("lw replay no alloc", scb_alloc, 0);
    chk("lw partial not done", replay_done, 0);
    tick();
    idle();
    @(negedge clk);
    chk("after replay grant replay", iss_replay, 0);
    chk("after replay grant payload", iss_payload, 64'hA1);
    tick();
    idle(); fb_pos_valid = 1; fb_pos_mask = 8'hF0;
    @(negedge clk);
    chk("lw replay_done", replay_done, 1);
    chk("lw replay_done id", replay_done_scb_id, 2);
    chk("lw done iss_replay", iss_replay, 0);
    chk("lw done alu payload", iss_payload, 64'hA1);
    tick();
    idle(); iss_grt = 1;
    @(negedge clk);
    chk("alu after lw occ", occupancy, 1);
    chk("alu after lw alloc", scb_alloc, 1);
    tick();
    idle();
    @(negedge clk);
    chk("lw seq drained occ", occupancy, 0);
    chk("lw seq drained req", iss_req, 0);
    tick();

    // SW with fb_zero: oc_full blocks, then replay beats a ready head
    idle(); wr_valid_0 = 1; wr_payload_0 = 64'hB0; wr_mem_0 = 1;
    wr_valid_1 = 1; wr_payload_1 = 64'hB1; tick();
    idle(); iss_grt = 1; scb_id = 2'd1;
    @(negedge clk);
    chk("sw head alloc", scb_alloc, 1);
    tick();
    idle(); fb_zero_valid = 1; oc_full = 1;
    @(negedge clk);
    chk("sw oc_full blocks", iss_req, 0);
    tick();
    idle(); iss_grt = 1;
    @(negedge clk);
    chk("sw replay req", iss_req, 1);
    chk("sw replay priority", iss_replay, 1);
    chk("sw replay payload", iss_payload, 64'hB0);
    chk("sw replay scb_id", iss_scb_id, 1);
    chk("sw replay mask", iss_mask, 8'hFF);
    tick();
    idle(); fb_pos_valid = 1; fb_pos_mask = 8'hFF;
    @(negedge clk);
    chk("sw replay_done", replay_done, 1);
    chk("sw replay_done id", replay_done_scb_id, 1);
    chk("sw done head payload", iss_payload, 64'hB1);
    tick();
    idle(); iss_grt = 1;
    @(negedge clk);
    chk("sw alu alloc", scb_alloc, 1);
    chk("sw alu occ", occupancy, 1);
    tick();
    idle();
    @(negedge clk);
    chk("sw seq drained", occupancy, 0);
    tick();

    // EXIT behind an LW with a replay pending
    idle(); wr_valid_0 = 1; wr_payload_0 = 64'hC0; wr_mem_0 = 1;
    wr_valid_1 = 1; wr_payload_1 = 64'hC1; wr_exit_1 = 1; tick();
    idle(); iss_grt = 1; scb_id = 2'd3;
    @(negedge clk);
    chk("exit seq lw alloc", scb_alloc, 1);
    tick();
    idle(); fb_zero_valid = 1;
    @(negedge clk);
    chk("exit seq replay same cycle", iss_replay, 1);
    chk("exit blocked by replay", exit_req, 0);
    tick();
    idle(); iss_grt = 1;
    @(negedge clk);
    chk("exit seq replay pending", iss_replay, 1);
    chk("exit blocked pending", exit_req, 0);
    tick();
    idle(); fb_pos_valid = 1; fb_pos_mask = 8'hFF; scb_empty = 0;
    @(negedge clk);
    chk("exit seq replay_done", replay_done, 1);
    chk("exit seq replay_done id", replay_done_scb_id, 3);
    chk("exit head not issued", iss_req, 0);
    chk("exit blocked at done", exit_req, 0);
    tick();
    idle(); scb_empty = 0;
    @(negedge clk);
    chk("exit blocked by scoreboard", exit_req, 0);
    chk("exit seq occ", occupancy, 1);
    tick();
    idle(); exit_grt = 1;
    @(negedge clk);
    chk("exit_req ready", exit_req, 1);
    tick();
    idle();
    @(negedge clk);
    chk("exit retired", exit_req, 0);
    chk("exit retired occ", occupancy, 0);
    tick();

    // Asynchronous reset mid-cycle
    idle(); wr_valid_0 = 1; wr_payload_0 = 64'hD0; wr_valid_1 = 1; wr_payload_1 = 64'hD1;
    tick();
    idle();
    chk("pre-rst overflow sticky", overflow_err, 1);
    chk("pre-rst occ", occupancy, 2);
    #1 rst = 1;
    #1;
    chk("async rst occ", occupancy, 0);
    chk("async rst iss_req", iss_req, 0);
    chk("async rst overflow", overflow_err, 0);
    chk("async rst req_if", req_if, 1);
    chk("async rst exit_req", exit_req, 0);
    #1 rst = 0;
    tick();
    idle(); wr_valid_0 = 1; wr_payload_0 = 64'hE0; tick();
    idle();
    @(negedge clk);
    chk("post-rst write req", iss_req, 1);
    chk("post-rst write payload", iss_payload, 64'hE0);
    chk("post-rst occ", occupancy, 1);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
